// File: rtl/board_evt_pkg.sv
// rtl/board_evt_pkg.sv - shared widths, scan state and bit-search helper for the board event detector
package board_evt_pkg;

    localparam int EVT_W   = 6;
    localparam int SQ_W    = 5;
    localparam int BOARD_W = 32;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    // Index of the lowest set bit; callers only use it on a non-zero vector.
    function automatic logic [SQ_W-1:0] lowest_set(input logic [BOARD_W-1:0] v);
        logic [SQ_W-1:0] idx;
        idx = '0;
        for (int i = BOARD_W - 1; i >= 0; i--) begin
            if (v[i]) idx = SQ_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - synchronous event FIFO with registered head output and full/empty flags
module event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_ptr_nxt;
    logic [AW:0]   rd_ptr_nxt;
    logic          do_push;
    logic          do_pop;
    logic [W-1:0]  head_nxt;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};

    // The head register must see an entry written this same cycle, so bypass the array.
    always_comb begin
        head_nxt = '0;
        if (wr_ptr_nxt != rd_ptr_nxt) begin
            if (do_push && (rd_ptr_nxt[AW-1:0] == wr_ptr[AW-1:0])) begin
                head_nxt = push_data;
            end else begin
                head_nxt = mem[rd_ptr_nxt[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            head_data <= '0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            head_data <= head_nxt;
        end
    end

endmodule

// File: rtl/board_event_detector.sv
// rtl/board_event_detector.sv - debounced board snapshot and per-square place/lift events; SENSOR_INVERT_EN inverts sensors
module board_event_detector
    import board_evt_pkg::*;
#(
    parameter int STABLE_COUNT = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] sensor_in,
    input  logic        sample_tick,
    output logic [31:0] board_state,
    output logic        evt_valid,
    output logic [5:0]  evt_data,
    input  logic        evt_ready,
    output logic        busy
);

    localparam logic [3:0] ACCEPT_CNT = 4'(STABLE_COUNT - 1);

    state_t             state;
    logic [BOARD_W-1:0] sample;
    logic [BOARD_W-1:0] candidate;
    logic [BOARD_W-1:0] diff;
    logic [3:0]         stable_cnt;
    logic [3:0]         cnt_inc;
    logic               sample_match;
    logic               accept;
    logic [SQ_W-1:0]    scan_sq;
    logic [EVT_W-1:0]   scan_evt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               push;

`ifdef SENSOR_INVERT_EN
    assign sample = ~sensor_in;
`else
    assign sample = sensor_in;
`endif

    assign sample_match = (sample == candidate);
    assign cnt_inc      = (stable_cnt == 4'd15) ? 4'd15 : stable_cnt + 4'd1;
    // The count is compared after this tick's increment, so the run includes the current sample.
    assign accept       = sample_tick && sample_match && (cnt_inc >= ACCEPT_CNT)
                          && (state == IDLE) && (candidate != board_state);

    assign scan_sq   = lowest_set(diff);
    assign scan_evt  = {board_state[scan_sq], scan_sq};
    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;
    assign push      = (state == SCAN) && (diff != '0) && (!fifo_full || pop);
    assign busy      = (state == SCAN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            board_state <= '0;
            candidate   <= '0;
            stable_cnt  <= '0;
            diff        <= '0;
        end else begin
            if (sample_tick) begin
                if (sample_match) begin
                    stable_cnt <= cnt_inc;
                end else begin
                    candidate  <= sample;
                    stable_cnt <= '0;
                end
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        board_state <= candidate;
                        diff        <= board_state ^ candidate;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (push) begin
                        diff <= diff & (diff - 1);
                        if ((diff & (diff - 1)) == '0) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVT_W)
    ) u_event_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (scan_evt),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (evt_data)
    );

endmodule

// File: tb/tb_board_event_detector.sv
// tb/tb_board_event_detector.sv - randomized and directed checks of board_event_detector against a queue model
module tb_board_event_detector;

    localparam int STABLE_COUNT = 4;
    localparam int FIFO_DEPTH   = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] sensor_in;
    logic        sample_tick;
    logic [31:0] board_state;
    logic        evt_valid;
    logic [5:0]  evt_data;
    logic        evt_ready;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cycles;

    logic [31:0] m_board;
    logic [31:0] m_last;
    int          m_run;
    logic [5:0]  m_pend[$];
    logic [5:0]  m_fifo[$];
    logic [5:0]  dut_log[$];

    board_event_detector #(
        .STABLE_COUNT (STABLE_COUNT),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sensor_in   (sensor_in),
        .sample_tick (sample_tick),
        .board_state (board_state),
        .evt_valid   (evt_valid),
        .evt_data    (evt_data),
        .evt_ready   (evt_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] to_sensor(input logic [31:0] v);
`ifdef SENSOR_INVERT_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic model_reset();
        m_board = '0;
        m_last  = '0;
        m_run   = 1;
        m_pend.delete();
        m_fifo.delete();
    endtask

    // Whole-board view: a snapshot seen STABLE_COUNT times in a row while idle becomes the board,
    // its changed squares queue up in ascending order and move into an 8-deep FIFO one per cycle.
    task automatic model_step(input logic tick, input logic [31:0] val, input logic rdy);
        bit was_idle;
        bit do_pop;
        bit room;
        was_idle = (m_pend.size() == 0);
        do_pop   = rdy && (m_fifo.size() > 0);
        room     = (m_fifo.size() < FIFO_DEPTH) || do_pop;
        if (do_pop) void'(m_fifo.pop_front());
        if (m_pend.size() > 0 && room) m_fifo.push_back(m_pend.pop_front());
        if (tick) begin
            if (val == m_last) begin
                if (m_run < 16) m_run++;
                if (m_run >= STABLE_COUNT && was_idle && val != m_board) begin
                    for (int i = 0; i < 32; i++) begin
                        if (val[i] != m_board[i]) m_pend.push_back({val[i], 5'(i)});
                    end
                    m_board = val;
                end
            end else begin
                m_last = val;
                m_run  = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("board_state", board_state, m_board);
        check("busy", 32'(busy), 32'(m_pend.size() != 0));
        check("evt_valid", 32'(evt_valid), 32'(m_fifo.size() != 0));
        check("evt_data", 32'(evt_data), (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'd0);
        if (busy) busy_cycles++;
    endtask

    task automatic cycle(input logic tick, input logic [31:0] val, input logic rdy);
        sample_tick = tick;
        sensor_in   = to_sensor(val);
        evt_ready   = rdy;
        if (evt_valid && evt_ready) dut_log.push_back(evt_data);
        @(posedge clk);
        model_step(tick, val, rdy);
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n, input logic [31:0] val, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b1, val, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, rdy);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        sample_tick = 1'b0;
        sensor_in   = to_sensor(32'h0);
        evt_ready   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_drain(input string tag);
        check({tag, "_count"}, 32'(dut_log.size()), 32'd32);
        for (int i = 0; i < 32; i++) begin
            if (i < dut_log.size()) check({tag, "_evt"}, 32'(dut_log[i]), 32'h20 + 32'(i));
        end
    endtask

    initial begin
        logic [31:0] v;
        busy_cycles = 0;
        rst_n       = 1'b0;
        sample_tick = 1'b0;
        sensor_in   = to_sensor(32'h0);
        evt_ready   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_board", board_state, 32'h0);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(evt_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // First snapshot 0x5: place square 0, then square 2.
        dut_log.delete();
        busy_cycles = 0;
        ticks(4, 32'h5, 1'b1);
        idle(8, 1'b1);
        check("s5_board", board_state, 32'h5);
        check("s5_count", 32'(dut_log.size()), 32'd2);
        if (dut_log.size() == 2) begin
            check("s5_evt0", 32'(dut_log[0]), 32'h20);
            check("s5_evt1", 32'(dut_log[1]), 32'h22);
        end
        check("s5_busy_cycles", 32'(busy_cycles), 32'd2);

        // 0x5 -> 0x6: lift square 0, place square 1.
        dut_log.delete();
        ticks(4, 32'h6, 1'b1);
        idle(8, 1'b1);
        check("s6_count", 32'(dut_log.size()), 32'd2);
        if (dut_log.size() == 2) begin
            check("s6_evt0", 32'(dut_log[0]), 32'h00);
            check("s6_evt1", 32'(dut_log[1]), 32'h21);
        end

        // Glitching input never settles long enough.
        dut_log.delete();
        for (int i = 0; i < 10; i++) cycle(1'b1, (i % 2 == 0) ? 32'h1 : 32'h0, 1'b1);
        idle(6, 1'b1);
        check("glitch_count", 32'(dut_log.size()), 32'd0);
        check("glitch_board", board_state, 32'h6);

        // Full board with a stalled consumer, then drain in square order.
        do_reset();
        dut_log.delete();
        ticks(4, 32'hFFFF_FFFF, 1'b0);
        idle(20, 1'b0);
        check("full_busy_held", 32'(busy), 32'd1);
        check("full_nothing_popped", 32'(dut_log.size()), 32'd0);
        idle(60, 1'b1);
        check_drain("full_drain");

        // Reset in the middle of a scan, then rescan from square 0.
        do_reset();
        ticks(4, 32'hFFFF_FFFF, 1'b1);
        idle(5, 1'b1);
        sample_tick = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(evt_valid), 32'd0);
        check("midrst_board", board_state, 32'h0);
        check("midrst_busy", 32'(busy), 32'd0);
        model_reset();
        dut_log.delete();
        @(negedge clk);
        rst_n = 1'b1;
        ticks(4, 32'hFFFF_FFFF, 1'b1);
        idle(60, 1'b1);
        check_drain("midrst_drain");

        // Random snapshots with random ticks and consumer stalls.
        v = 32'h0;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom & $urandom & $urandom;
                1: v = v ^ (32'h1 << $urandom_range(0, 31));
                2: v = $urandom;
                default: v = v;
            endcase
            for (int h = 0; h < int'($urandom_range(1, 7)); h++) begin
                cycle($urandom_range(0, 3) != 0, v, $urandom_range(0, 3) != 0);
            end
        end
        idle(80, 1'b1);
        check("rand_final_valid", 32'(evt_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
